// File: rtl/rr_packet_arbiter.sv
// Round-robin packet arbiter: NUM_REQ valid/ready sources share one downstream port.
// The grant is held for a whole packet, and priority rotates once the last beat is accepted.
module rr_packet_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  output logic [ID_W-1:0]           out_id,
  input  logic                      out_ready,
  output logic                      busy
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] gid_q, gid_d;

  logic            win_found;
  logic [ID_W-1:0] win_id;
  logic [ID_W:0]   cand;
  logic [ID_W:0]   gid_inc;

  // Walk the offsets from the highest down, so the last hit is the one closest to ptr.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (req_valid[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    out_id    = '0;
    if (state_q == GRANT) begin
      out_valid         = req_valid[gid_q];
      out_data          = req_data[int'(gid_q)*DATA_W +: DATA_W];
      out_last          = req_valid[gid_q] & req_last[gid_q];
      out_id            = gid_q;
      req_ready[gid_q]  = out_ready;
    end
  end

  assign busy = (state_q == GRANT);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    gid_inc = {1'b0, gid_q} + 1'b1;
    if (gid_inc == NUM_REQ_W) begin
      gid_inc = '0;
    end
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gid_d   = win_id;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Only a completed packet releases the grant; a mid-packet valid gap just stalls.
        if (out_valid && out_ready && out_last) begin
          ptr_d   = gid_inc[ID_W-1:0];
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
    end
  end

endmodule
